// File: rtl/udma_eth_pkg.sv
// Shared types and Ethernet sizing constants for the uDMA Ethernet TX path.
package udma_eth_pkg;

    localparam int ETH_MIN_PAYLOAD = 60;
    localparam int ETH_MAX_PAYLOAD = 1514;
    localparam int ETH_HDR_BYTES   = 2;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_PAD,
        S_DROP
    } eth_tx_state_e;

endpackage

// File: rtl/udma_eth_tx_framer.sv
// Turns the header-prefixed uDMA TX byte stream into AXIS frames for the MAC:
// strips the 2-byte little-endian length, pads to the Ethernet minimum, drops oversize frames.
module udma_eth_tx_framer
    import udma_eth_pkg::*;
#(
    parameter int         LEN_WIDTH = ETH_HDR_BYTES * 8,
    parameter int         MIN_LEN   = ETH_MIN_PAYLOAD,
    parameter int         MAX_LEN   = ETH_MAX_PAYLOAD,
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input  logic        clk_eth,
    input  logic        rst_eth,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [7:0]  eth_tx_axis_tdata,
    output logic        eth_tx_axis_tvalid,
    input  logic        eth_tx_axis_tready,
    output logic        eth_tx_axis_tlast,
    output logic        eth_tx_axis_tuser,
    output logic        frame_done_o,
    output logic        frame_err_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] err_cnt_o
);

    localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] ONE   = LEN_WIDTH'(1);

    eth_tx_state_e        state_q, state_d;
    logic [7:0]           len_lo_q, len_lo_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [LEN_WIDTH-1:0] pad_q, pad_d;
    logic [LEN_WIDTH-1:0] hdr_len;

    logic [7:0]           tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [15:0]          err_cnt_q, err_cnt_d;

    logic                 out_free;
    logic                 load;
    logic [7:0]           ld_data;
    logic                 ld_last;
    logic                 s_ready;
    logic                 err_pulse;
    logic                 done_pulse;

    assign out_free   = !tvalid_q || eth_tx_axis_tready;
    assign hdr_len    = LEN_WIDTH'({s_data_i, len_lo_q});
    assign done_pulse = tvalid_q && eth_tx_axis_tready && tlast_q;

    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        rem_d     = rem_q;
        pad_d     = pad_q;
        s_ready   = 1'b0;
        load      = 1'b0;
        ld_data   = s_data_i;
        ld_last   = 1'b0;
        err_pulse = 1'b0;

        case (state_q)
            S_LEN_LO: begin
                s_ready = 1'b1;
                if (s_valid_i) begin
                    len_lo_d = s_data_i;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                s_ready = 1'b1;
                if (s_valid_i) begin
                    if (hdr_len == '0) begin
                        err_pulse = 1'b1;
                        state_d   = S_LEN_LO;
                    end else if (hdr_len > MAX_L) begin
                        // The oversize payload is still in the stream and must be swallowed.
                        err_pulse = 1'b1;
                        rem_d     = hdr_len;
                        state_d   = S_DROP;
                    end else begin
                        rem_d   = hdr_len;
                        pad_d   = (hdr_len < MIN_L) ? (MIN_L - hdr_len) : '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                s_ready = out_free;
                if (s_valid_i && out_free) begin
                    load    = 1'b1;
                    ld_last = (rem_q == ONE) && (pad_q == '0);
                    rem_d   = rem_q - ONE;
                    if (rem_q == ONE) begin
                        state_d = (pad_q != '0) ? S_PAD : S_LEN_LO;
                    end
                end
            end
            S_PAD: begin
                if (out_free) begin
                    load    = 1'b1;
                    ld_data = PAD_BYTE;
                    ld_last = (pad_q == ONE);
                    pad_d   = pad_q - ONE;
                    if (pad_q == ONE) begin
                        state_d = S_LEN_LO;
                    end
                end
            end
            S_DROP: begin
                s_ready = 1'b1;
                if (s_valid_i) begin
                    rem_d = rem_q - ONE;
                    if (rem_q == ONE) begin
                        state_d = S_LEN_LO;
                    end
                end
            end
            default: state_d = S_LEN_LO;
        endcase
    end

    // Output slice holds its contents whenever the MAC stalls a valid beat.
    always_comb begin
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (out_free) begin
            tvalid_d = load;
            tlast_d  = load && ld_last;
            if (load) begin
                tdata_d = ld_data;
            end
        end

        if (done_pulse) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (err_pulse && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_eth) begin
        if (rst_eth) begin
            state_q     <= S_LEN_LO;
            len_lo_q    <= '0;
            rem_q       <= '0;
            pad_q       <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            rem_q       <= rem_d;
            pad_q       <= pad_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign s_ready_o          = s_ready;
    assign eth_tx_axis_tdata  = tdata_q;
    assign eth_tx_axis_tvalid = tvalid_q;
    assign eth_tx_axis_tlast  = tlast_q;
    assign eth_tx_axis_tuser  = 1'b0;
    assign frame_done_o       = done_pulse;
    assign frame_err_o        = err_pulse;
    assign frame_cnt_o        = frame_cnt_q;
    assign err_cnt_o          = err_cnt_q;

endmodule

// File: tb/tb_udma_eth_tx_framer.sv
// Bench for udma_eth_tx_framer: table of frames plus random frames, checked against a frame-level model.
module tb_udma_eth_tx_framer;

    localparam int MIN_LEN = 60;
    localparam int MAX_LEN = 1514;

    logic        clk_eth = 1'b0;
    logic        rst_eth = 1'b1;
    logic [7:0]  s_data_i = 8'h00;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        tlast;
    logic        tuser;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    udma_eth_tx_framer dut (
        .clk_eth            (clk_eth),
        .rst_eth            (rst_eth),
        .s_data_i           (s_data_i),
        .s_valid_i          (s_valid_i),
        .s_ready_o          (s_ready_o),
        .eth_tx_axis_tdata  (tdata),
        .eth_tx_axis_tvalid (tvalid),
        .eth_tx_axis_tready (tready),
        .eth_tx_axis_tlast  (tlast),
        .eth_tx_axis_tuser  (tuser),
        .frame_done_o       (frame_done),
        .frame_err_o        (frame_err),
        .frame_cnt_o        (frame_cnt),
        .err_cnt_o          (err_cnt)
    );

    always #5 clk_eth = ~clk_eth;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        int         len;
        logic [7:0] base;
        bit         rnd;
        int         exp_beats;
        int         exp_done;
        int         exp_err;
    } vec_t;

    beat_t      act_q[$];
    beat_t      exp_q[$];
    logic [7:0] pl_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int done_pulses = 0;
    int err_pulses = 0;
    int exp_frame_cnt = 0;
    int exp_err_cnt = 0;
    bit rnd_ready = 1'b0;
    bit gap_mode = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_eth);
            #1;
            tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Observes handshakes, pulses and the hold-while-stalled rule at the falling edge.
    initial begin : mon
        logic  stall_prev;
        beat_t held;
        beat_t cur;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk_eth);
            if (rst_eth) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    n_checks++;
                    if (!tvalid || tdata != held.d || tlast != held.l) begin
                        n_errors++;
                        $display("FAIL stall_hold: got v=%0b d=%02h l=%0b expected v=1 d=%02h l=%0b",
                                 tvalid, tdata, tlast, held.d, held.l);
                    end
                end
                cur.d = tdata;
                cur.l = tlast;
                if (tvalid && tready) act_q.push_back(cur);
                stall_prev = tvalid && !tready;
                held = cur;
                if (frame_done) done_pulses++;
                if (frame_err) err_pulses++;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: a frame either yields max(len, MIN_LEN) beats or is rejected outright.
    task automatic model_frame(input int len);
        beat_t b;
        int    n;
        if (len == 0 || len > MAX_LEN) begin
            if (exp_err_cnt < 65535) exp_err_cnt++;
        end else begin
            n = (len < MIN_LEN) ? MIN_LEN : len;
            for (int i = 0; i < n; i++) begin
                b.d = (i < len) ? pl_q[i] : 8'h00;
                b.l = (i == n - 1);
                exp_q.push_back(b);
            end
            exp_frame_cnt = (exp_frame_cnt + 1) % 65536;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        if (gap_mode && $urandom_range(0, 3) == 0) begin
            s_valid_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk_eth);
            #1;
        end
        s_data_i  = b;
        s_valid_i = 1'b1;
        guard = 0;
        do begin
            @(negedge clk_eth);
            guard++;
        end while (!s_ready_o && guard < 5000);
        if (!s_ready_o) chk("s_ready_timeout", 0, 1);
        @(posedge clk_eth);
        #1;
        s_valid_i = 1'b0;
    endtask

    task automatic send_frame(input int len);
        logic [15:0] l16;
        l16 = 16'(len);
        send_byte(l16[7:0]);
        send_byte(l16[15:8]);
        for (int i = 0; i < len; i++) send_byte(pl_q[i]);
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while ((act_q.size() < exp_q.size() || tvalid) && cyc < 20000) begin
            @(posedge clk_eth);
            #1;
            cyc++;
        end
        if (cyc >= 20000) chk("drain_timeout", 0, 1);
    endtask

    task automatic compare_beats(input string tag);
        int mism;
        int first;
        int n;
        mism  = 0;
        first = -1;
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (act_q[i] != exp_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        chk({tag, "_beat_count"}, act_q.size(), exp_q.size());
        chk($sformatf("%s_bad_beats(first=%0d)", tag, first), mism, 0);
        act_q.delete();
        exp_q.delete();
    endtask

    vec_t vecs[11];

    initial begin
        int d0, e0, f0, r0, len, sel;

        vecs[0]  = '{64,   8'h00, 1'b0, 64,   1, 0};
        vecs[1]  = '{10,   8'hA0, 1'b0, 60,   1, 0};
        vecs[2]  = '{1515, 8'h33, 1'b0, 0,    0, 1};
        vecs[3]  = '{60,   8'h50, 1'b0, 60,   1, 0};
        vecs[4]  = '{0,    8'h00, 1'b0, 0,    0, 1};
        vecs[5]  = '{60,   8'h70, 1'b0, 60,   1, 0};
        vecs[6]  = '{100,  8'hC0, 1'b1, 100,  1, 0};
        vecs[7]  = '{1,    8'h5A, 1'b0, 60,   1, 0};
        vecs[8]  = '{1514, 8'h01, 1'b0, 1514, 1, 0};
        vecs[9]  = '{59,   8'h90, 1'b1, 60,   1, 0};
        vecs[10] = '{61,   8'h22, 1'b0, 61,   1, 0};

        repeat (3) @(posedge clk_eth);
        #1;
        rst_eth = 1'b0;
        @(negedge clk_eth);
        chk("rst_tvalid", int'(tvalid), 0);
        chk("rst_tlast", int'(tlast), 0);
        chk("rst_tdata", int'(tdata), 0);
        chk("rst_tuser", int'(tuser), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_s_ready", int'(s_ready_o), 1);
        @(posedge clk_eth);
        #1;

        for (int r = 0; r < 11; r++) begin
            rnd_ready = vecs[r].rnd;
            gap_mode  = vecs[r].rnd;
            d0 = done_pulses;
            e0 = err_pulses;
            pl_q.delete();
            for (int i = 0; i < vecs[r].len; i++) pl_q.push_back(vecs[r].base + 8'(i));
            model_frame(vecs[r].len);
            send_frame(vecs[r].len);
            wait_drain();
            chk($sformatf("row%0d_beats", r), act_q.size(), vecs[r].exp_beats);
            compare_beats($sformatf("row%0d", r));
            chk($sformatf("row%0d_done_pulses", r), done_pulses - d0, vecs[r].exp_done);
            chk($sformatf("row%0d_err_pulses", r), err_pulses - e0, vecs[r].exp_err);
            chk($sformatf("row%0d_frame_cnt", r), int'(frame_cnt), exp_frame_cnt);
            chk($sformatf("row%0d_err_cnt", r), int'(err_cnt), exp_err_cnt);
        end

        // Back-to-back random frames: headers may be taken while a tlast is still stalled.
        rnd_ready = 1'b1;
        gap_mode  = 1'b1;
        d0 = done_pulses;
        e0 = err_pulses;
        f0 = exp_frame_cnt;
        r0 = exp_err_cnt;
        for (int k = 0; k < 12; k++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) len = 0;
            else if (sel == 1) len = $urandom_range(MAX_LEN + 1, MAX_LEN + 16);
            else len = $urandom_range(1, 150);
            pl_q.delete();
            for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
            model_frame(len);
            send_frame(len);
        end
        wait_drain();
        compare_beats("rand");
        chk("rand_done_pulses", done_pulses - d0, exp_frame_cnt - f0);
        chk("rand_err_pulses", err_pulses - e0, exp_err_cnt - r0);
        chk("rand_frame_cnt", int'(frame_cnt), exp_frame_cnt);
        chk("rand_err_cnt", int'(err_cnt), exp_err_cnt);

        // Reset in the middle of a len=80 payload, then a clean len=60 frame.
        rnd_ready = 1'b0;
        gap_mode  = 1'b0;
        @(posedge clk_eth);
        #1;
        send_byte(8'd80);
        send_byte(8'd0);
        for (int i = 0; i < 30; i++) send_byte(8'(i));
        rst_eth = 1'b1;
        @(posedge clk_eth);
        #1;
        rst_eth = 1'b0;
        @(negedge clk_eth);
        chk("midrst_tvalid", int'(tvalid), 0);
        chk("midrst_tlast", int'(tlast), 0);
        chk("midrst_frame_cnt", int'(frame_cnt), 0);
        chk("midrst_err_cnt", int'(err_cnt), 0);
        chk("midrst_s_ready", int'(s_ready_o), 1);
        @(posedge clk_eth);
        #1;
        act_q.delete();
        exp_q.delete();
        exp_frame_cnt = 0;
        exp_err_cnt   = 0;
        d0 = done_pulses;
        pl_q.delete();
        for (int i = 0; i < 60; i++) pl_q.push_back(8'h10 + 8'(i));
        model_frame(60);
        send_frame(60);
        wait_drain();
        compare_beats("post_rst");
        chk("post_rst_done_pulses", done_pulses - d0, 1);
        chk("post_rst_frame_cnt", int'(frame_cnt), 1);
        chk("post_rst_err_cnt", int'(err_cnt), 0);
        chk("final_tuser", int'(tuser), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
